lut_counter: RTL

Parametrised loadable up/down counter driving a programmable lookup-table output. It is the successor to the fixed 8-bit load/increment counter with a hard-coded four-entry decode. This block adds:
- configurable widths and table depth,
- up/down counting with a wrap or saturate policy,
- run-time LUT and default-entry writes,
- a registered output with a hit flag and a wrap strobe.

It sits as a small sequencing/decode element between control logic and downstream datapath configuration.

---
 rtl/lut_counter_pkg.sv | 25 ++
 rtl/lut_counter_table.sv | 71 +++++++
 rtl/lut_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/lut_counter_pkg.sv
// -----------------------------------------------------------------------------
// lut_counter_pkg
// Shared definitions for the lut_counter block:
//   DIR_UP / DIR_DN       - encodings of the dir input
//   entry_reset_value()   - power-on content of table entry idx for a given
//                           entry width: ((idx+1)*16) mod 2**out_w
// -----------------------------------------------------------------------------
package lut_counter_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Returned 64 bits wide so one function serves any entry width; callers
    // size the result to OUT_W. Index DEPTH gives the default entry's value.
    function automatic logic [63:0] entry_reset_value(input int unsigned idx,
                                                      input int unsigned out_w);
        logic [63:0] v;
        v = 64'(idx + 1) << 4;
        if (out_w < 64) begin
            v = v & ((64'd1 << out_w) - 64'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/lut_counter_table.sv
// -----------------------------------------------------------------------------
// lut_counter_table
// Programmable lookup table with a default entry and a registered lookup.
//   clk, rst_n   - clock, asynchronous active-low reset
//   index        - lookup index (the counter value)
//   lut_we       - write lut[lut_addr] with lut_wdata (ignored if addr >= DEPTH)
//   lut_addr     - table write address
//   lut_wdata    - write data, shared by the table and the default entry
//   def_we       - write the default entry with lut_wdata
//   out          - registered lookup result
//   hit          - 1 when out came from a table entry, 0 when from the default
// -----------------------------------------------------------------------------
module lut_counter_table
    import lut_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OUT_W = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] index,
    input  logic             lut_we,
    input  logic [AW-1:0]    lut_addr,
    input  logic [OUT_W-1:0] lut_wdata,
    input  logic             def_we,
    output logic [OUT_W-1:0] out,
    output logic             hit
);

    logic [OUT_W-1:0] lut [DEPTH];
    logic [OUT_W-1:0] def_entry;

    logic index_in_table;
    logic addr_in_table;

    // Compare at 32 bits so non-power-of-two depths are bounded correctly.
    assign index_in_table = (32'(index) < DEPTH);
    assign addr_in_table  = (32'(lut_addr) < DEPTH);

    // NOTE: the table is a handful of flops, not a RAM macro, so every entry is
    // reset; that is what lets rst_n restore the power-on contents at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut[i] <= OUT_W'(entry_reset_value(i, OUT_W));
            end
            def_entry <= OUT_W'(entry_reset_value(DEPTH, OUT_W));
            out       <= '0;
            hit       <= 1'b0;
        end else begin
            if (lut_we && addr_in_table) begin
                lut[lut_addr] <= lut_wdata;
            end
            if (def_we) begin
                def_entry <= lut_wdata;
            end
            // Reads the pre-write contents, so a same-cycle write to the
            // looked-up entry shows up one edge later.
            if (index_in_table) begin
                out <= lut[index[AW-1:0]];
                hit <= 1'b1;
            end else begin
                out <= def_entry;
                hit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lut_counter.sv
// -----------------------------------------------------------------------------
// lut_counter
// Loadable up/down counter whose value indexes a programmable lookup table.
//   clk, rst_n   - clock, asynchronous active-low reset
//   sel          - load count with data (highest priority)
//   data         - load value
//   en           - count enable
//   dir          - DIR_UP (0) increment, DIR_DN (1) decrement
//   lut_we       - write table entry lut_addr with lut_wdata
//   lut_addr     - table write address
//   lut_wdata    - table / default entry write data
//   def_we       - write the default entry with lut_wdata
//   count        - current counter value
//   out          - registered lookup of count (one cycle behind count)
//   hit          - out came from a table entry (count < DEPTH)
//   wrap         - one-cycle strobe alongside a wrapped count (SATURATE=0)
// -----------------------------------------------------------------------------
module lut_counter
    import lut_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int OUT_W    = 8,
    parameter bit SATURATE = 1'b0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             dir,
    input  logic             lut_we,
    input  logic [AW-1:0]    lut_addr,
    input  logic [OUT_W-1:0] lut_wdata,
    input  logic             def_we,
    output logic [WIDTH-1:0] count,
    output logic [OUT_W-1:0] out,
    output logic             hit,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    // NOTE: defaults first so every path assigns both outputs and no latch is
    // inferred; hold and "no strobe" are the natural defaults here.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (sel) begin
            count_nxt = data;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (count == CNT_MAX) begin
                    if (!SATURATE) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end else begin
                if (count == '0) begin
                    if (!SATURATE) begin
                        count_nxt = CNT_MAX;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count - CNT_ONE;
                end
            end
        end
    end

    // NOTE: non-blocking assignments for all registered state, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // The table indexes the registered count, which gives out/hit their
    // one-cycle latency relative to count.
    lut_counter_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (count),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .def_we    (def_we),
        .out       (out),
        .hit       (hit)
    );

endmodule
